sram_fifo_1rw: RTL and testbench
================================

SRAM_FIFO_1RW -- requirements
Module: sram_fifo_1rw

Interface
REQ-001 SHALL have parameter W, default 32: data width in bits.
REQ-002 SHALL have parameter N, default 64: SRAM depth in entries; power of two, >= 4.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port arst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port push_vld  input  1  producer has a word.
REQ-006 SHALL have port push_data  input  W  producer word.
REQ-007 SHALL have port push_rdy  output  1  word accepted when push_vld & push_rdy.
REQ-008 SHALL have port pop_vld  output  1  head word available.
REQ-009 SHALL have port pop_data  output  W  head word.
REQ-010 SHALL have port pop_rdy  input  1  consumer takes head when pop_vld & pop_rdy.
REQ-011 SHALL have port count  output  $clog2(N)+2  total words held (SRAM + in-flight + output buffer).
REQ-012 SHALL have port sram_addr  output  $clog2(N)  address to 1RW SRAM.
REQ-013 SHALL have port sram_din  output  W  write data to SRAM.
REQ-014 SHALL have port sram_cs_n  output  1  SRAM chip select, active-low.
REQ-015 SHALL have port sram_we_n  output  1  SRAM write enable, active-low; high = read.
REQ-016 SHALL have port sram_dout  input  W  SRAM read data, valid the cycle after a read access.

Function
REQ-017 SHALL keep registered state: wr_ptr, rd_ptr ($clog2(N) bits, wrap N-1 -> 0), sram_cnt (0..N), inflight flag, 3-entry output FIFO with buf_cnt (0..3).
REQ-018 SHALL compute rd_req = (sram_cnt != 0) & (buf_cnt + inflight < 3), from registered state only.
REQ-019 SHALL drive push_rdy = (sram_cnt != N) & ~rd_req, from registered state only; no path from push_vld or pop_rdy.
REQ-020 SHALL, when rd_req: sram_cs_n=0, sram_we_n=1, sram_addr=rd_ptr; rd_ptr+=1, sram_cnt-=1, inflight<=1 at edge.
REQ-021 SHALL, when ~rd_req & push_vld & push_rdy: sram_cs_n=0, sram_we_n=0, sram_addr=wr_ptr, sram_din=push_data; wr_ptr+=1, sram_cnt+=1 at edge.
REQ-022 SHALL otherwise drive sram_cs_n=1, sram_we_n=1; read priority over write, at most one access per cycle.
REQ-023 SHALL, when inflight=1, capture sram_dout into output FIFO tail that edge; inflight<=0 unless a new read issues.
REQ-024 SHALL drive pop_vld = (buf_cnt != 0), pop_data = output FIFO head, both registered-state driven.
REQ-025 SHALL handle capture and pop in the same cycle: buf_cnt unchanged, order preserved, no loss or duplication.
REQ-026 SHALL deliver words in strict push order; minimum latency push accept (cycle t) -> pop_vld high cycle t+3.
REQ-027 SHALL sustain one pop per cycle while sram_cnt>0 and no pushes are pending.
REQ-028 SHALL drive count = sram_cnt + inflight + buf_cnt; maximum N+3.
REQ-029 SHALL ignore pop_rdy when pop_vld=0 and push_vld when push_rdy=0 (no state change).

Reset
REQ-030 SHALL, on arst_n=0, immediately clear wr_ptr, rd_ptr, sram_cnt, inflight, buf_cnt; pop_vld=0, count=0, sram_cs_n=1, sram_we_n=1, push_rdy=1 after release.
REQ-031 SHALL, on reset mid-operation, discard all held and in-flight data; SRAM contents not cleared and never read before rewrite.

Verification
REQ-032 SHALL cover: reset release, no stimulus -> pop_vld=0, push_rdy=1, count=0, sram_cs_n=1 every cycle.
REQ-033 SHALL cover: push 0xA5 at cycle 0, pop_rdy=1 -> write at addr 0 cycle 0, read addr 0 cycle 1, pop_vld=1 with pop_data=0xA5 at cycle 3, count back to 0.
REQ-034 SHALL cover: pop_rdy=0, push continuously -> push_rdy drops after N+3 accepted words, count=N+3, 3 read accesses interleaved.
REQ-035 SHALL cover: from full, pop_rdy=1 only -> N+3 words popped in push order, one per cycle after first, pointers wrap to 0.
REQ-036 SHALL cover: random push_vld/pop_rdy, 10*N words -> scoreboard order matches, never cs_n=0 with both read and write, count matches model.
REQ-037 SHALL cover: arst_n asserted with count=5 and a read in flight -> pop_vld=0 and count=0 immediately; next push pops correctly after 3 cycles.

Source files
------------

// File: rtl/sram_fifo_1rw.sv
// FIFO built on an external single-port SRAM with a 3-entry output buffer.
// Ports: push_vld/rdy/data in, pop_vld/rdy/data out, count, sram_* 1RW port.
module sram_fifo_1rw #(
  parameter int W = 32,
  parameter int N = 64
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   push_vld,
  input  logic [W-1:0]           push_data,
  output logic                   push_rdy,
  output logic                   pop_vld,
  output logic [W-1:0]           pop_data,
  input  logic                   pop_rdy,
  output logic [$clog2(N)+1:0]   count,
  output logic [$clog2(N)-1:0]   sram_addr,
  output logic [W-1:0]           sram_din,
  output logic                   sram_cs_n,
  output logic                   sram_we_n,
  input  logic [W-1:0]           sram_dout
);

  localparam int AW = $clog2(N);
  localparam logic [AW:0] FULL = (AW+1)'(N);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   sram_cnt_q, sram_cnt_d;
  logic          infl_q, infl_d;
  logic [1:0]    hd_q, hd_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [W-1:0]  buf_q [3];

  logic          rd_req;
  logic          wr_en;
  logic          pop_en;
  logic [2:0]    tl_sum;
  logic [1:0]    tl;

  // Reserve a buffer slot for every read so a returning word always fits.
  assign rd_req = (sram_cnt_q != '0) &&
                  (({1'b0, bcnt_q} + {2'b0, infl_q}) < 3'd3);
  assign push_rdy = (sram_cnt_q != FULL) && !rd_req;
  assign wr_en    = push_vld && push_rdy;
  assign pop_vld  = (bcnt_q != 2'd0);
  assign pop_data = buf_q[hd_q];
  assign pop_en   = pop_vld && pop_rdy;

  // Output buffer is a 3-slot ring: tail = (head + fill) mod 3.
  assign tl_sum = {1'b0, hd_q} + {1'b0, bcnt_q};
  assign tl     = (tl_sum >= 3'd3) ? 2'(tl_sum - 3'd3) : tl_sum[1:0];

  assign count = (AW+2)'(sram_cnt_q) + (AW+2)'(infl_q) + (AW+2)'(bcnt_q);

  always_comb begin
    sram_cs_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_addr  = wr_ptr_q;
    sram_din   = push_data;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sram_cnt_d = sram_cnt_q;
    infl_d     = rd_req;
    hd_d       = hd_q;
    bcnt_d     = bcnt_q;
    if (rd_req) begin
      sram_cs_n  = 1'b0;
      sram_addr  = rd_ptr_q;
      rd_ptr_d   = rd_ptr_q + 1'b1;
      sram_cnt_d = sram_cnt_q - 1'b1;
    end else if (wr_en) begin
      sram_cs_n  = 1'b0;
      sram_we_n  = 1'b0;
      wr_ptr_d   = wr_ptr_q + 1'b1;
      sram_cnt_d = sram_cnt_q + 1'b1;
    end
    if (pop_en) begin
      hd_d = (hd_q == 2'd2) ? 2'd0 : hd_q + 2'd1;
    end
    unique case ({infl_q, pop_en})
      2'b10:   bcnt_d = bcnt_q + 2'd1;
      2'b01:   bcnt_d = bcnt_q - 2'd1;
      default: bcnt_d = bcnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sram_cnt_q <= '0;
      infl_q     <= 1'b0;
      hd_q       <= 2'd0;
      bcnt_q     <= 2'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sram_cnt_q <= sram_cnt_d;
      infl_q     <= infl_d;
      hd_q       <= hd_d;
      bcnt_q     <= bcnt_d;
    end
  end

  // Data slots need no reset; the fill count gates their visibility.
  always_ff @(posedge clk) begin
    if (infl_q) begin
      buf_q[tl] <= sram_dout;
    end
  end

endmodule

// File: tb/tb_sram_fifo_1rw.sv
// Self-checking bench for sram_fifo_1rw with a behavioural SRAM.
// Ports: none; drives the DUT and prints one summary line.
module tb_sram_fifo_1rw;

  localparam int W  = 16;
  localparam int N  = 8;
  localparam int AW = $clog2(N);
  localparam int CW = AW + 2;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          push_vld;
  logic [W-1:0]  push_data;
  logic          push_rdy;
  logic          pop_vld;
  logic [W-1:0]  pop_data;
  logic          pop_rdy;
  logic [CW-1:0] count;
  logic [AW-1:0] sram_addr;
  logic [W-1:0]  sram_din;
  logic          sram_cs_n;
  logic          sram_we_n;
  logic [W-1:0]  sram_dout;

  logic [W-1:0]  mem [N];

  sram_fifo_1rw #(.W(W), .N(N)) dut (
    .clk(clk), .arst_n(arst_n),
    .push_vld(push_vld), .push_data(push_data), .push_rdy(push_rdy),
    .pop_vld(pop_vld), .pop_data(pop_data), .pop_rdy(pop_rdy),
    .count(count), .sram_addr(sram_addr), .sram_din(sram_din),
    .sram_cs_n(sram_cs_n), .sram_we_n(sram_we_n), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!sram_cs_n) begin
      if (!sram_we_n) mem[sram_addr] <= sram_din;
      else sram_dout <= mem[sram_addr];
    end
  end

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO contents as a queue plus event counters.
  logic [W-1:0] sb [$];
  int cyc, n_acc, n_pop, n_wr, n_rd;
  int first_pop, last_pop, last_acc;

  task automatic clear_model();
    sb.delete();
    n_acc = 0; n_pop = 0; n_wr = 0; n_rd = 0;
    first_pop = -1; last_pop = -1; last_acc = -1;
  endtask

  // Called once per cycle, after inputs settle, before the rising edge.
  task automatic observe();
    logic acc, pop, wr, rd;
    acc = push_vld && push_rdy;
    pop = pop_vld && pop_rdy;
    wr  = !sram_cs_n && !sram_we_n;
    rd  = !sram_cs_n && sram_we_n;
    chk("count", 64'(count), 64'(sb.size()));
    chk("wr_iff_acc", 64'(wr), 64'(acc));
    if (wr) begin
      chk("wr_addr", 64'(sram_addr), 64'(n_wr % N));
      chk("wr_din", 64'(sram_din), 64'(push_data));
      n_wr++;
    end
    if (rd) begin
      chk("rd_blocks_push", 64'(push_rdy), 64'(0));
      chk("rd_addr", 64'(sram_addr), 64'(n_rd % N));
      n_rd++;
    end
    if (sb.size() >= N + 3) chk("full_rdy", 64'(push_rdy), 64'(0));
    if (pop_vld) chk("vld_nonempty", 64'(sb.size() != 0), 64'(1));
    if (pop && sb.size() != 0) begin
      chk("pop_data", 64'(pop_data), 64'(sb.pop_front()));
      if (n_pop == 0) first_pop = cyc;
      last_pop = cyc;
      n_pop++;
    end
    if (acc) begin
      sb.push_back(push_data);
      n_acc++;
      last_acc = cyc;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_n = 1'b0; push_vld = 1'b0; pop_rdy = 1'b0; push_data = '0;
    #1;
    chk("rst_pop_vld", 64'(pop_vld), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    @(negedge clk);
    arst_n = 1'b1;
    clear_model();
  endtask

  typedef struct packed {
    logic          pv;
    logic [W-1:0]  pd;
    logic          pr;
    logic          e_prdy;
    logic          e_pvld;
    logic          chk_d;
    logic [W-1:0]  e_pdata;
    logic [CW-1:0] e_cnt;
    logic          e_cs_n;
    logic          e_we_n;
    logic [AW-1:0] e_addr;
  } vec_t;

  vec_t vec [8];

  initial begin
    vec[0] = '{1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 5'd0, 1'b1, 1'b1, 3'd0};
    vec[1] = '{1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 5'd0, 1'b1, 1'b1, 3'd0};
    vec[2] = '{1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 5'd0, 1'b1, 1'b1, 3'd0};
    vec[3] = '{1'b1, 16'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 5'd0, 1'b0, 1'b0, 3'd0};
    vec[4] = '{1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 5'd1, 1'b0, 1'b1, 3'd0};
    vec[5] = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 5'd1, 1'b1, 1'b1, 3'd0};
    vec[6] = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b1, 1'b1, 16'hA5, 5'd1, 1'b1, 1'b1, 3'd0};
    vec[7] = '{1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0, 5'd0, 1'b1, 1'b1, 3'd0};

    cyc = 0;
    clear_model();
    arst_n = 1'b0; push_vld = 1'b0; pop_rdy = 1'b0; push_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("inrst_cs_n", 64'(sram_cs_n), 64'(1));
    chk("inrst_push_rdy", 64'(push_rdy), 64'(1));
    @(negedge clk);
    arst_n = 1'b1;

    // Idle after reset, then a single word end to end.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      push_vld = vec[i].pv; push_data = vec[i].pd; pop_rdy = vec[i].pr;
      #1;
      chk($sformatf("v%0d_push_rdy", i), 64'(push_rdy), 64'(vec[i].e_prdy));
      chk($sformatf("v%0d_pop_vld", i), 64'(pop_vld), 64'(vec[i].e_pvld));
      chk($sformatf("v%0d_count", i), 64'(count), 64'(vec[i].e_cnt));
      chk($sformatf("v%0d_cs_n", i), 64'(sram_cs_n), 64'(vec[i].e_cs_n));
      chk($sformatf("v%0d_we_n", i), 64'(sram_we_n), 64'(vec[i].e_we_n));
      if (!vec[i].e_cs_n)
        chk($sformatf("v%0d_addr", i), 64'(sram_addr), 64'(vec[i].e_addr));
      if (!vec[i].e_we_n)
        chk($sformatf("v%0d_din", i), 64'(sram_din), 64'(vec[i].pd));
      if (vec[i].chk_d)
        chk($sformatf("v%0d_pop_data", i), 64'(pop_data), 64'(vec[i].e_pdata));
    end

    // Fill with consumer stalled.
    do_reset();
    pop_rdy = 1'b0;
    for (int i = 0; i < 3 * N + 10; i++) begin
      @(negedge clk);
      push_vld = 1'b1; push_data = W'($urandom);
      #1; observe();
    end
    chk("fill_accepted", 64'(n_acc), 64'(N + 3));
    chk("fill_reads", 64'(n_rd), 64'(3));
    chk("fill_count", 64'(count), 64'(N + 3));
    chk("fill_push_rdy", 64'(push_rdy), 64'(0));

    // Drain from full.
    for (int i = 0; i < 3 * N + 10 && n_pop < N + 3; i++) begin
      @(negedge clk);
      push_vld = 1'b0; pop_rdy = 1'b1;
      #1; observe();
    end
    chk("drain_pops", 64'(n_pop), 64'(N + 3));
    chk("drain_rate", 64'(last_pop - first_pop), 64'(N + 2));
    chk("drain_reads", 64'(n_rd), 64'(N + 3));
    @(negedge clk);
    #1;
    chk("drain_count", 64'(count), 64'(0));
    chk("drain_pop_vld", 64'(pop_vld), 64'(0));

    // Random traffic.
    do_reset();
    for (int i = 0; i < 100 * N && n_pop < 10 * N; i++) begin
      @(negedge clk);
      push_vld = (n_acc < 10 * N) ? 1'($urandom_range(0, 2) != 0) : 1'b0;
      push_data = W'($urandom);
      pop_rdy = 1'($urandom_range(0, 1));
      #1; observe();
    end
    chk("rand_pops", 64'(n_pop), 64'(10 * N));
    chk("rand_left", 64'(sb.size()), 64'(0));

    // Reset with a read in flight.
    do_reset();
    for (int i = 0; i < 40 && n_acc < 6; i++) begin
      @(negedge clk);
      push_vld = 1'b1; push_data = W'($urandom); pop_rdy = 1'b0;
      #1; observe();
    end
    chk("r37_acc", 64'(n_acc), 64'(6));
    repeat (3) begin
      @(negedge clk);
      push_vld = 1'b0; pop_rdy = 1'b0;
      #1; observe();
    end
    @(negedge clk);
    pop_rdy = 1'b1;
    #1;
    chk("r37_pop_vld", 64'(pop_vld), 64'(1));
    observe();
    @(negedge clk);
    pop_rdy = 1'b0;
    #1;
    chk("r37_read", 64'(!sram_cs_n && sram_we_n), 64'(1));
    observe();
    @(negedge clk);
    #1; observe();
    chk("r37_count5", 64'(count), 64'(5));
    #1;
    arst_n = 1'b0;
    #1;
    chk("r37_rst_pop_vld", 64'(pop_vld), 64'(0));
    chk("r37_rst_count", 64'(count), 64'(0));
    chk("r37_rst_cs_n", 64'(sram_cs_n), 64'(1));
    chk("r37_rst_push_rdy", 64'(push_rdy), 64'(1));
    @(negedge clk);
    arst_n = 1'b1;
    clear_model();
    @(negedge clk);
    push_vld = 1'b1; push_data = 16'h3C3C; pop_rdy = 1'b1;
    #1; observe();
    for (int i = 0; i < 10 && n_pop == 0; i++) begin
      @(negedge clk);
      push_vld = 1'b0;
      #1; observe();
    end
    chk("r37_pops", 64'(n_pop), 64'(1));
    chk("r37_latency", 64'(last_pop - last_acc), 64'(3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
